// File: rtl/branch_sequencer_if.sv
// Control-unit <-> branch sequencer signal bundle: request side plus the
// datapath strobes the sequencer drives during branch T3..T6.
interface branch_sequencer_if;
    logic        start;
    logic [31:0] ir;
    logic        con_q;
    logic        busy;
    logic        done;
    logic        taken;
    logic        Gra;
    logic        Rout;
    logic        conIn;
    logic        PCout;
    logic        Yin;
    logic        Cout;
    logic        alu_add;
    logic        Zin;
    logic        Zlowout;
    logic        PCin;
    // latched instruction; the Ra and C fields are decoded from this copy
    logic [31:0] ir_lat;

    modport master (
        output start, ir, con_q,
        input  busy, done, taken, Gra, Rout, conIn, PCout, Yin, Cout,
               alu_add, Zin, Zlowout, PCin, ir_lat
    );

    modport slave (
        input  start, ir, con_q,
        output busy, done, taken, Gra, Rout, conIn, PCout, Yin, Cout,
               alu_add, Zin, Zlowout, PCin, ir_lat
    );
endinterface

// File: rtl/branch_sequencer.sv
// Conditional-branch step sequencer: holds Ra on the bus for CON to settle,
// builds PC + C in Z, and loads PC only when the CON flip-flop says taken.
module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010,
    parameter int         CON_LAT   = 4
) (
    input logic               clk,
    input logic               clear_n,
    branch_sequencer_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for a branch start
    // EVAL  | Ra on bus, conIn held for CON_LAT cycles
    // LOADY | PC -> Y
    // ADD   | Y + C -> Z, sample CON result
    // WRITE | Z -> PC when taken, done pulse
    typedef enum logic [2:0] {IDLE, EVAL, LOADY, ADD, WRITE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(CON_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] ir_q;
    logic        busy_q, done_q, taken_q;
    logic        gra_q, rout_q, conin_q;
    logic        pcout_q, yin_q;
    logic        cout_q, alu_add_q, zin_q;
    logic        zlowout_q, pcin_q;

    // outputs are loaded alongside the state they belong to, so every strobe
    // is a flop and nothing on the request side reaches them combinationally
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ir_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            gra_q     <= 1'b0;
            rout_q    <= 1'b0;
            conin_q   <= 1'b0;
            pcout_q   <= 1'b0;
            yin_q     <= 1'b0;
            cout_q    <= 1'b0;
            alu_add_q <= 1'b0;
            zin_q     <= 1'b0;
            zlowout_q <= 1'b0;
            pcin_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            gra_q     <= 1'b0;
            rout_q    <= 1'b0;
            conin_q   <= 1'b0;
            pcout_q   <= 1'b0;
            yin_q     <= 1'b0;
            cout_q    <= 1'b0;
            alu_add_q <= 1'b0;
            zin_q     <= 1'b0;
            zlowout_q <= 1'b0;
            pcin_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && (bus.ir[31:27] == BR_OPCODE)) begin
                        state_q <= EVAL;
                        ir_q    <= bus.ir;
                        cnt_q   <= CNT_INIT;
                        busy_q  <= 1'b1;
                        gra_q   <= 1'b1;
                        rout_q  <= 1'b1;
                        conin_q <= 1'b1;
                    end
                end
                EVAL: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= LOADY;
                        pcout_q <= 1'b1;
                        yin_q   <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                        gra_q   <= 1'b1;
                        rout_q  <= 1'b1;
                        conin_q <= 1'b1;
                    end
                end
                LOADY: begin
                    state_q   <= ADD;
                    cout_q    <= 1'b1;
                    alu_add_q <= 1'b1;
                    zin_q     <= 1'b1;
                end
                ADD: begin
                    state_q   <= WRITE;
                    taken_q   <= bus.con_q;
                    pcin_q    <= bus.con_q;
                    zlowout_q <= 1'b1;
                    done_q    <= 1'b1;
                end
                WRITE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.taken   = taken_q;
    assign bus.Gra     = gra_q;
    assign bus.Rout    = rout_q;
    assign bus.conIn   = conin_q;
    assign bus.PCout   = pcout_q;
    assign bus.Yin     = yin_q;
    assign bus.Cout    = cout_q;
    assign bus.alu_add = alu_add_q;
    assign bus.Zin     = zin_q;
    assign bus.Zlowout = zlowout_q;
    assign bus.PCin    = pcin_q;
    assign bus.ir_lat  = ir_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: a CON_LAT=4 instance and a CON_LAT=1
// instance, checked cycle by cycle against hand-written strobe patterns.
module tb_branch_sequencer;
    logic clk = 1'b0;
    logic clear_n;
    always #5 clk = ~clk;

    branch_sequencer_if bus4 ();
    branch_sequencer_if bus1 ();

    branch_sequencer #(.BR_OPCODE(5'b10010), .CON_LAT(4)) u_dut4 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus4.slave)
    );

    branch_sequencer #(.BR_OPCODE(5'b10010), .CON_LAT(1)) u_dut1 (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus1.slave)
    );

    // strobe order: Gra Rout conIn PCout Yin Cout alu_add Zin Zlowout PCin
    localparam logic [9:0] S_IDLE  = 10'b0000000000;
    localparam logic [9:0] S_EVAL  = 10'b1110000000;
    localparam logic [9:0] S_LOADY = 10'b0001100000;
    localparam logic [9:0] S_ADD   = 10'b0000011100;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vec(input int sel);
        if (sel == 1)
            return {19'd0, bus1.busy, bus1.done, bus1.taken, bus1.Gra, bus1.Rout,
                    bus1.conIn, bus1.PCout, bus1.Yin, bus1.Cout, bus1.alu_add,
                    bus1.Zin, bus1.Zlowout, bus1.PCin};
        return {19'd0, bus4.busy, bus4.done, bus4.taken, bus4.Gra, bus4.Rout,
                bus4.conIn, bus4.PCout, bus4.Yin, bus4.Cout, bus4.alu_add,
                bus4.Zin, bus4.Zlowout, bus4.PCin};
    endfunction

    function automatic logic [31:0] ir_lat(input int sel);
        return (sel == 1) ? bus1.ir_lat : bus4.ir_lat;
    endfunction

    function automatic logic [31:0] ex(input logic b, input logic d, input logic t,
                                       input logic [9:0] s);
        return {19'd0, b, d, t, s};
    endfunction

    task automatic drive(input int sel, input logic s, input logic [31:0] i, input logic c);
        if (sel == 1) begin
            bus1.start = s; bus1.ir = i; bus1.con_q = c;
        end else begin
            bus4.start = s; bus4.ir = i; bus4.con_q = c;
        end
    endtask

    // One full branch from IDLE. con_q is toggled in WRITE to show it is only
    // sampled at ADD; ir is scrambled after accept to show the latch holds.
    task automatic run_branch(input string tag, input int sel, input int cl,
                              input logic [31:0] ir_v, input logic con_v,
                              input logic prev_t, input bit pulse);
        logic [31:0] stray;
        stray = 32'h9012_3456;
        drive(sel, 1'b1, ir_v, 1'b0);
        tick();
        drive(sel, 1'b0, ~ir_v, con_v);
        for (int i = 1; i <= cl; i++) begin
            check($sformatf("%s_eval%0d", tag, i), vec(sel), ex(1'b1, 1'b0, prev_t, S_EVAL));
            if (pulse && i == 1) drive(sel, 1'b1, stray, con_v);
            else                 drive(sel, 1'b0, ~ir_v, con_v);
            tick();
        end
        drive(sel, 1'b0, ~ir_v, con_v);
        check({tag, "_loady"}, vec(sel), ex(1'b1, 1'b0, prev_t, S_LOADY));
        tick();
        check({tag, "_add"}, vec(sel), ex(1'b1, 1'b0, prev_t, S_ADD));
        tick();
        check({tag, "_write"}, vec(sel), ex(1'b1, 1'b1, con_v, {9'b000000001, con_v}));
        check({tag, "_irlat"}, ir_lat(sel), ir_v);
        drive(sel, pulse, stray, ~con_v);
        tick();
        drive(sel, 1'b0, ~ir_v, ~con_v);
        check({tag, "_idle"}, vec(sel), ex(1'b0, 1'b0, con_v, S_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_n = 1'b0;
        drive(0, 1'b0, 32'h0, 1'b0);
        drive(1, 1'b0, 32'h0, 1'b0);
        #1;
        check("rst4_vec", vec(0), 32'h0);
        check("rst1_vec", vec(1), 32'h0);
        check("rst4_ir", ir_lat(0), 32'h0);
        tick();
        tick();
        clear_n = 1'b1;
        tick();

        run_branch("taken4", 0, 4, 32'h9000_0014, 1'b1, 1'b0, 1'b0);
        run_branch("nottaken4", 0, 4, 32'h9000_0014, 1'b0, 1'b1, 1'b0);
        run_branch("pulse4", 0, 4, 32'h9123_4567, 1'b1, 1'b0, 1'b1);
        // accepted in the cycle right after done
        run_branch("backtoback4", 0, 4, 32'h9400_0ABC, 1'b1, 1'b1, 1'b0);

        drive(0, 1'b1, 32'h1800_0014, 1'b0);
        tick();
        drive(0, 1'b0, 32'h1800_0014, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("nonbr_%0d", i), vec(0), ex(1'b0, 1'b0, 1'b1, S_IDLE));
            tick();
        end
        check("nonbr_irlat", ir_lat(0), 32'h9400_0ABC);

        drive(0, 1'b1, 32'h9000_0014, 1'b1);
        tick();
        drive(0, 1'b0, 32'h9000_0014, 1'b1);
        tick();
        check("pre_rst_eval", vec(0), ex(1'b1, 1'b0, 1'b1, S_EVAL));
        clear_n = 1'b0;
        #1;
        check("rst_async_vec", vec(0), 32'h0);
        check("rst_async_ir", ir_lat(0), 32'h0);
        tick();
        tick();
        check("rst_hold_vec", vec(0), 32'h0);
        clear_n = 1'b1;
        tick();
        check("rst_release_idle", vec(0), 32'h0);

        run_branch("postrst4", 0, 4, 32'h97FF_FFFF, 1'b1, 1'b0, 1'b0);
        run_branch("taken1", 1, 1, 32'h9000_0014, 1'b1, 1'b0, 1'b0);
        run_branch("nottaken1", 1, 1, 32'h9123_4567, 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Control-step sequencer for the conditional-branch instruction class (brzr/brnz/brpl/brmi).
- Sits on the other side of the CON flip-flop: it drives the CON evaluate strobe and holds the Ra value on the bus while CON settles.
- It then sequences the PC-relative target computation and consumes the CON result to decide whether PCin fires.
- It takes over the branch T3–T6 steps from the main control unit and hands completion back with a done pulse.

Parameters:
- BR_OPCODE, 5'b10010, value of ir[31:27] that identifies a branch instruction.
- CON_LAT, 4, cycles conIn and the Ra bus drive are held so the CON flip-flop's internal register chain settles. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request from the control unit to execute the branch in ir.
- ir  in  32  instruction register contents, sampled when start is accepted.
- con_q  in  1  Q output of the CON flip-flop.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at the end of the sequence.
- taken  out  1  branch decision, valid with done and held until the next accepted start.
- Gra  out  1  select Ra field of the latched instruction onto the register-file decode.
- Rout  out  1  drive the selected register onto the bus.
- conIn  out  1  CON flip-flop load enable.
- PCout  out  1  drive PC onto the bus.
- Yin  out  1  load Y register.
- Cout  out  1  drive sign-extended ir[18:0] (C field) onto the bus.
- alu_add  out  1  ALU operation select = ADD.
- Zin  out  1  load Z register.
- Zlowout  out  1  drive Z[31:0] onto the bus.
- PCin  out  1  load PC from the bus.

Behaviour:
- Reset (clear_n low, asynchronous):
  - state = IDLE, counter = 0, latched ir = 0.
  - busy, done and taken are 0, and every control strobe is 0.
  - These values take effect immediately, without waiting for a clock edge, including in mid-sequence.
- All outputs are registered, i.e. decoded from registered state. No combinational path exists from start or con_q to any output.
- Control strobes are mutually exclusive by state. A strobe not listed for a state is 0 in that state.
- IDLE:
  - busy = 0.
  - If start = 1 and ir[31:27] = BR_OPCODE: latch ir, load counter = CON_LAT-1, go to EVAL.
  - If start = 1 with any other opcode: ignore it and stay in IDLE. No strobes fire and taken is unchanged.
- EVAL:
  - Outputs: Gra = Rout = conIn = 1.
  - Counter decrements each cycle. When the counter reaches 0, go to LOADY.
  - Dwell in EVAL is exactly CON_LAT cycles.
- LOADY: PCout = Yin = 1 for one cycle, then go to ADD.
- ADD: Cout = alu_add = Zin = 1 for one cycle, then go to WRITE. Also register taken <= con_q on this edge.
- WRITE:
  - Outputs: Zlowout = 1, PCin = taken, done = 1.
  - Next state is IDLE.
- Latency:
  - start accepted at edge N gives done high in cycle N+CON_LAT+3.
  - Total busy length is CON_LAT+3 cycles.
  - A not-taken branch still runs every step except that PCin stays 0.
- start while busy: ignored. A start coincident with done, i.e. while in WRITE, is also ignored. The earliest re-accept is the cycle after done.
- Once a sequence is accepted, a change on ir does not affect it.
- taken:
  - Changes only at the ADD->WRITE edge or on reset.
  - It is not cleared when a new start is accepted; it is overwritten by the next ADD->WRITE edge.
  - For CON_LAT = 1, con_q is still sampled only at ADD.
- con_q is treated as a level. X on con_q outside the ADD sampling edge has no effect.

Test Plan:
- Reset/idle: clear_n=0 for 2 cycles mid-EVAL, then release → all strobes, busy, done, taken = 0 in the same cycle clear_n falls; state IDLE; next start accepted normally.
- Taken brzr, CON_LAT=4: start with ir=0x90000014, con_q=1 from the cycle after start →
  - conIn/Gra/Rout high for exactly 4 cycles.
  - Then PCout+Yin for 1 cycle, then Cout+alu_add+Zin for 1 cycle.
  - Then Zlowout+PCin+done, with taken=1.
  - done lands 7 cycles after the start edge.
- Not taken: same stimulus with con_q=0 → identical strobe sequence except PCin=0 in WRITE; taken=0; done after 7 cycles.
- Non-branch opcode: start with ir[31:27]=5'b00011 → busy stays 0, no strobe ever asserts, taken keeps its previous value.
- Start during busy and at done: pulse start in EVAL and in WRITE → both ignored. A start the cycle after done is accepted, and busy rises the following cycle.
- CON_LAT=1 build: taken branch → conIn high 1 cycle, done 4 cycles after start; con_q toggled to 0 after ADD has no effect on taken.
